rst_seq_ctrl: RTL and testbench

Reset sequencer placed directly downstream of the reset synchronizer. It receives the synchronized chip reset and releases a vector of per-domain active-low resets one at a time, in a fixed order with a programmable spacing. Release only starts after the clock source lock has been stable for a filter period. It also services software reset requests by re-asserting all domains for a minimum hold time and then re-running the sequence.

---
 rtl/rst_seq_ctrl.sv | 156 +++++++++++++++
 tb/tb_rst_seq_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: qualifies clock lock, then releases per-domain active-low
// resets in index order with fixed spacing; services software reset requests.
module rst_seq_ctrl #(
  parameter int NumDomains = 4,
  parameter int StageDelay = 16,
  parameter int LockFilter = 8,
  parameter int SwRstHold  = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  lock_i,
  input  logic                  sw_rst_req_i,
  output logic [NumDomains-1:0] rst_no,
  output logic                  seq_done_o,
  output logic                  busy_o,
  output logic                  sw_rst_ack_o
);

  localparam int MaxA   = (LockFilter > StageDelay) ? LockFilter : StageDelay;
  localparam int MaxCnt = (MaxA > SwRstHold) ? MaxA : SwRstHold;
  localparam int CntW   = $clog2(MaxCnt + 1);
  localparam int IdxW   = $clog2(NumDomains) + 1;

  typedef enum logic [1:0] {
    WAIT_LOCK,
    RELEASE,
    RUN,
    HOLD
  } state_e;

  state_e                state_q, state_d;
  logic [CntW-1:0]       lock_cnt_q, lock_cnt_d;
  logic [CntW-1:0]       stage_cnt_q, stage_cnt_d;
  logic [CntW-1:0]       hold_cnt_q, hold_cnt_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic [NumDomains-1:0] rst_q, rst_d;
  logic                  done_q, done_d;
  logic                  busy_q, busy_d;
  logic                  ack_q, ack_d;

  // Every output is computed one cycle ahead here and registered below.
  always_comb begin
    state_d     = state_q;
    lock_cnt_d  = lock_cnt_q;
    stage_cnt_d = stage_cnt_q;
    hold_cnt_d  = hold_cnt_q;
    idx_d       = idx_q;
    rst_d       = rst_q;
    done_d      = done_q;
    busy_d      = busy_q;
    ack_d       = 1'b0;

    unique case (state_q)
      WAIT_LOCK: begin
        if (!lock_i) begin
          lock_cnt_d = '0;
        end else if (lock_cnt_q == CntW'(LockFilter - 1)) begin
          lock_cnt_d  = '0;
          stage_cnt_d = '0;
          rst_d       = '0;
          rst_d[0]    = 1'b1;
          if (NumDomains == 1) begin
            state_d = RUN;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end else begin
            state_d = RELEASE;
            idx_d   = IdxW'(1);
          end
        end else begin
          lock_cnt_d = lock_cnt_q + 1'b1;
        end
      end

      RELEASE, RUN: begin
        // Lock loss outranks a software request and suppresses its ack.
        if (!lock_i) begin
          state_d    = WAIT_LOCK;
          lock_cnt_d = '0;
          rst_d      = '0;
          done_d     = 1'b0;
          busy_d     = 1'b1;
        end else if (sw_rst_req_i) begin
          state_d    = HOLD;
          hold_cnt_d = '0;
          rst_d      = '0;
          done_d     = 1'b0;
          busy_d     = 1'b1;
          ack_d      = 1'b1;
        end else if (state_q == RELEASE) begin
          if (stage_cnt_q == CntW'(StageDelay - 1)) begin
            stage_cnt_d = '0;
            for (int i = 0; i < NumDomains; i++) begin
              if (idx_q == IdxW'(i)) rst_d[i] = 1'b1;
            end
            idx_d = idx_q + 1'b1;
            if (idx_q == IdxW'(NumDomains - 1)) begin
              state_d = RUN;
              done_d  = 1'b1;
              busy_d  = 1'b0;
            end
          end else begin
            stage_cnt_d = stage_cnt_q + 1'b1;
          end
        end
      end

      HOLD: begin
        if (hold_cnt_q == CntW'(SwRstHold - 1)) begin
          state_d    = WAIT_LOCK;
          hold_cnt_d = '0;
          lock_cnt_d = '0;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = WAIT_LOCK;
        rst_d   = '0;
        done_d  = 1'b0;
        busy_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= WAIT_LOCK;
      lock_cnt_q  <= '0;
      stage_cnt_q <= '0;
      hold_cnt_q  <= '0;
      idx_q       <= '0;
      rst_q       <= '0;
      done_q      <= 1'b0;
      busy_q      <= 1'b1;
      ack_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      lock_cnt_q  <= lock_cnt_d;
      stage_cnt_q <= stage_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      idx_q       <= idx_d;
      rst_q       <= rst_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      ack_q       <= ack_d;
    end
  end

  assign rst_no       = rst_q;
  assign seq_done_o   = done_q;
  assign busy_o       = busy_q;
  assign sw_rst_ack_o = ack_q;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Scoreboard bench for rst_seq_ctrl: a driver pushes model predictions per
// edge, a monitor pops and compares them just after each rising edge.
module tb_rst_seq_ctrl;

  localparam int N  = 4;
  localparam int SD = 16;
  localparam int LF = 8;
  localparam int SH = 32;

  localparam int M_WAIT = 0;
  localparam int M_SEQ  = 1;
  localparam int M_HOLD = 2;

  logic         clk_i = 1'b0;
  logic         rst_ni = 1'b0;
  logic         lock_i = 1'b0;
  logic         sw_rst_req_i = 1'b0;
  logic [N-1:0] rst_no;
  logic         seq_done_o;
  logic         busy_o;
  logic         sw_rst_ack_o;

  typedef struct packed {
    logic [N-1:0] rst;
    logic         done;
    logic         busy;
    logic         ack;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  int m_mode = M_WAIT;
  int m_run = 0;
  int m_elapsed = 0;
  int m_held = 0;

  rst_seq_ctrl #(
    .NumDomains(N),
    .StageDelay(SD),
    .LockFilter(LF),
    .SwRstHold (SH)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .lock_i      (lock_i),
    .sw_rst_req_i(sw_rst_req_i),
    .rst_no      (rst_no),
    .seq_done_o  (seq_done_o),
    .busy_o      (busy_o),
    .sw_rst_ack_o(sw_rst_ack_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference: domains released = 1 + edges-since-qualification / StageDelay.
  task automatic model_step(input logic lock, input logic req, output exp_t e);
    int n;
    e.ack = 1'b0;
    case (m_mode)
      M_WAIT: begin
        if (lock) begin
          m_run++;
          if (m_run == LF) begin
            m_mode    = M_SEQ;
            m_elapsed = 0;
          end
        end else begin
          m_run = 0;
        end
      end
      M_SEQ: begin
        if (!lock) begin
          m_mode = M_WAIT;
          m_run  = 0;
        end else if (req) begin
          m_mode = M_HOLD;
          m_held = 0;
          e.ack  = 1'b1;
        end else if (m_elapsed < N * SD) begin
          m_elapsed++;
        end
      end
      default: begin
        m_held++;
        if (m_held == SH) begin
          m_mode = M_WAIT;
          m_run  = 0;
        end
      end
    endcase
    if (m_mode == M_SEQ) begin
      n = m_elapsed / SD + 1;
      if (n > N) n = N;
      e.rst  = N'((1 << n) - 1);
      e.done = (n == N);
      e.busy = (n != N);
    end else begin
      e.rst  = '0;
      e.done = 1'b0;
      e.busy = 1'b1;
    end
  endtask

  task automatic applyStimulus(input logic lock, input logic req);
    exp_t e;
    @(negedge clk_i);
    lock_i       = lock;
    sw_rst_req_i = req;
    model_step(lock, req, e);
    exp_q.push_back(e);
  endtask

  // Asserts reset between edges, checks the immediate effect, then releases mid-cycle.
  task automatic applyReset();
    @(posedge clk_i);
    #3;
    rst_ni = 1'b0;
    #1;
    checkOutput("async_rst_no", 32'(rst_no), 32'h0);
    checkOutput("async_seq_done", 32'(seq_done_o), 32'h0);
    checkOutput("async_busy", 32'(busy_o), 32'h1);
    checkOutput("async_ack", 32'(sw_rst_ack_o), 32'h0);
    lock_i       = 1'b0;
    sw_rst_req_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #3;
    rst_ni    = 1'b1;
    m_mode    = M_WAIT;
    m_run     = 0;
    m_elapsed = 0;
    m_held    = 0;
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk_i);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checkOutput("rst_no", 32'(rst_no), 32'(e.rst));
        checkOutput("seq_done", 32'(seq_done_o), 32'(e.done));
        checkOutput("busy", 32'(busy_o), 32'(e.busy));
        checkOutput("sw_rst_ack", 32'(sw_rst_ack_o), 32'(e.ack));
      end
    end
  end

  initial begin
    logic lock_r;
    logic req_r;
    int   req_hold;

    applyReset();
    repeat (70) applyStimulus(1'b1, 1'b0);

    // Lock loss in RUN, then a one-cycle dip during the lock filter.
    applyStimulus(1'b0, 1'b0);
    repeat (5) applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    repeat (70) applyStimulus(1'b1, 1'b0);

    applyStimulus(1'b1, 1'b1);
    repeat (100) applyStimulus(1'b1, 1'b0);

    // Lock loss after domain 1 has been released.
    applyStimulus(1'b0, 1'b0);
    repeat (LF + 20) applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    repeat (70) applyStimulus(1'b1, 1'b0);

    applyStimulus(1'b0, 1'b1);
    repeat (70) applyStimulus(1'b1, 1'b0);

    // A request held high is re-accepted right after the next RELEASE entry.
    repeat (60) applyStimulus(1'b1, 1'b1);
    repeat (70) applyStimulus(1'b1, 1'b0);

    req_hold = 0;
    for (int i = 0; i < 3000; i++) begin
      lock_r = ($urandom_range(0, 249) != 0);
      if (req_hold == 0 && $urandom_range(0, 99) < 2) req_hold = $urandom_range(1, 5);
      req_r = (req_hold > 0);
      if (req_hold > 0) req_hold--;
      applyStimulus(lock_r, req_r);
    end

    applyReset();
    repeat (30) applyStimulus(1'b1, 1'b0);
    applyReset();
    repeat (70) applyStimulus(1'b1, 1'b0);

    @(posedge clk_i);
    #2;
    checkOutput("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
